// File: rtl/dff_pipe_pkg.sv
// Shared sizing helpers for the dff_pipe pipeline register.
// Width functions are used by both the interface and the top module.
package dff_pipe_pkg;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // A one-stage pipe still needs a 1-bit tap select so the port exists.
  function automatic int tap_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int occ_width(input int depth);
    return clog2(depth + 1);
  endfunction

  localparam int DEPTH_DEFAULT = 4;
  localparam int TAP_W         = tap_width(DEPTH_DEFAULT);
  localparam int OCC_W         = occ_width(DEPTH_DEFAULT);

endpackage

// File: rtl/dff_pipe_if.sv
// Control, data and status bundle for dff_pipe; master drives, slave is the pipe.
interface dff_pipe_if
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEPTH_DEFAULT
);

  localparam int TAP_BITS = tap_width(DEPTH);
  localparam int OCC_BITS = occ_width(DEPTH);

  logic                en;
  logic                clr;
  logic [WIDTH-1:0]    d;
  logic                d_valid;
  logic [TAP_BITS-1:0] tap;
  logic [WIDTH-1:0]    q;
  logic                q_valid;
  logic [OCC_BITS-1:0] occ;
  logic                full;

  modport master (
    output en, clr, d, d_valid, tap,
    input  q, q_valid, occ, full
  );

  modport slave (
    input  en, clr, d, d_valid, tap,
    output q, q_valid, occ, full
  );

endinterface

// File: rtl/dff_stage.sv
// One pipeline stage: WIDTH data bits plus a valid bit, with async reset,
// synchronous clear (higher priority) and load enable.
module dff_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] q_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             valid_q;
  logic             valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clr_i) begin
      data_d  = RESET_VAL;
      valid_d = 1'b0;
    end else if (en_i) begin
      data_d  = d_i;
      valid_d = valid_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q_o     = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/dff_pipe.sv
// Programmable-delay pipeline: DEPTH chained dff_stage registers with valid
// tracking, an occupancy counter and a clamped combinational output tap.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = DEPTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic     clk,
  input  logic     rst_n,
  dff_pipe_if.slave bus
);

  localparam int TAP_BITS = tap_width(DEPTH);
  localparam int OCC_BITS = occ_width(DEPTH);

  logic [WIDTH-1:0]    stageData [DEPTH];
  logic [DEPTH-1:0]    stageValid;
  logic [OCC_BITS-1:0] occ_q;
  logic [OCC_BITS-1:0] occ_d;
  logic [TAP_BITS-1:0] tapSel;

  for (genvar i = 0; i < DEPTH; i++) begin : gStage
    logic [WIDTH-1:0] inData;
    logic             inValid;

    if (i == 0) begin : gHead
      assign inData  = bus.d;
      assign inValid = bus.d_valid;
    end else begin : gBody
      assign inData  = stageData[i-1];
      assign inValid = stageValid[i-1];
    end

    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (bus.en),
      .clr_i   (bus.clr),
      .d_i     (inData),
      .valid_i (inValid),
      .q_o     (stageData[i]),
      .valid_o (stageValid[i])
    );
  end

  // Incoming and departing valids may cancel; modular arithmetic keeps the
  // result exact even when the intermediate sum exceeds the counter width.
  always_comb begin
    occ_d = occ_q;
    if (bus.clr) begin
      occ_d = '0;
    end else if (bus.en) begin
      occ_d = occ_q + OCC_BITS'(bus.d_valid) - OCC_BITS'(stageValid[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  always_comb begin
    tapSel = bus.tap;
    if (DEPTH == 1) begin
      tapSel = '0;
    end else if (int'(bus.tap) >= DEPTH) begin
      tapSel = TAP_BITS'(DEPTH - 1);
    end
  end

  assign bus.q       = stageData[tapSel];
  assign bus.q_valid = stageValid[tapSel];
  assign bus.occ     = occ_q;
  assign bus.full    = (occ_q == OCC_BITS'(DEPTH));

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: a DEPTH=4 pipe tapped at its last stage checked against
// a scoreboard, plus a DEPTH=3 pipe for tap sweep/clamp and async reset.
module tb_dff_pipe;
  import dff_pipe_pkg::*;

  localparam logic [7:0] RV4 = 8'hA5;
  localparam logic [3:0] RV3 = 4'h5;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   fails  = 0;

  // Entries wait here until they reach the tapped last stage, then become shown4.
  entry_t sb4[$];
  entry_t shown4;

  dff_pipe_if #(.WIDTH(8), .DEPTH(4)) bus4 ();
  dff_pipe_if #(.WIDTH(4), .DEPTH(3)) bus3 ();

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  dff_pipe #(.WIDTH(4), .DEPTH(3), .RESET_VAL(RV3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int expOcc4();
    int n;
    n = int'(shown4.valid);
    foreach (sb4[i]) n += int'(sb4[i].valid);
    return n;
  endfunction

  task automatic resetModel4();
    sb4.delete();
    shown4 = '{valid: 1'b0, data: RV4};
  endtask

  task automatic drive4(input logic en, input logic clr, input logic [7:0] d, input logic v);
    bus4.en      = en;
    bus4.clr     = clr;
    bus4.d       = d;
    bus4.d_valid = v;
    if (en && !clr) sb4.push_back('{valid: v, data: d});
    cycle();
    if (clr) begin
      resetModel4();
    end else if (en && sb4.size() > 3) begin
      shown4 = sb4.pop_front();
    end
    bus4.clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus4.en      = 1'b0;
    bus4.clr     = 1'b0;
    bus4.d       = 8'h00;
    bus4.d_valid = 1'b0;
    bus4.tap     = TAP_W'(3);
    bus3.en      = 1'b0;
    bus3.clr     = 1'b0;
    bus3.d       = 4'h0;
    bus3.d_valid = 1'b0;
    bus3.tap     = 2'd0;
    resetModel4();
    repeat (2) cycle();
    checks++; if (bus4.q !== RV4) begin fails++; $display("[TB] FAIL reset_q: got %h expected %h", bus4.q, RV4); end
    checks++; if (bus4.q_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_qvalid: got %b expected 0", bus4.q_valid); end
    checks++; if (bus4.occ !== 3'd0) begin fails++; $display("[TB] FAIL reset_occ: got %0d expected 0", bus4.occ); end
    checks++; if (bus4.full !== 1'b0) begin fails++; $display("[TB] FAIL reset_full: got %b expected 0", bus4.full); end
    checks++; if (bus3.q !== RV3) begin fails++; $display("[TB] FAIL reset_q3: got %h expected %h", bus3.q, RV3); end
    checks++; if (bus3.occ !== 2'd0) begin fails++; $display("[TB] FAIL reset_occ3: got %0d expected 0", bus3.occ); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive4(1'b0, 1'b0, 8'($urandom), 1'b1);
      checks++; if (bus4.occ !== 3'd0) begin fails++; $display("[TB] FAIL hold_occ: got %0d expected 0", bus4.occ); end
      checks++; if (bus4.q_valid !== 1'b0 || bus4.q !== RV4) begin fails++; $display("[TB] FAIL hold_q: got %b/%h expected 0/%h", bus4.q_valid, bus4.q, RV4); end
    end
  endtask

  task automatic test_fill_latency();
    for (int k = 1; k <= 8; k++) begin
      drive4(1'b1, 1'b0, 8'(17 * k), 1'b1);
      checks++; if (bus4.q !== shown4.data || bus4.q_valid !== shown4.valid) begin fails++; $display("[TB] FAIL fill_q edge %0d: got %b/%h expected %b/%h", k, bus4.q_valid, bus4.q, shown4.valid, shown4.data); end
      checks++; if (bus4.occ !== 3'(expOcc4())) begin fails++; $display("[TB] FAIL fill_occ edge %0d: got %0d expected %0d", k, bus4.occ, expOcc4()); end
      checks++; if (bus4.full !== (expOcc4() == 4)) begin fails++; $display("[TB] FAIL fill_full edge %0d: got %b expected %b", k, bus4.full, expOcc4() == 4); end
    end
  endtask

  task automatic test_occupancy();
    for (int k = 0; k < 2; k++) begin
      drive4(1'b1, 1'b0, 8'hE1 + 8'(k), 1'b0);
      checks++; if (bus4.q !== shown4.data || bus4.q_valid !== shown4.valid) begin fails++; $display("[TB] FAIL drain_q: got %b/%h expected %b/%h", bus4.q_valid, bus4.q, shown4.valid, shown4.data); end
      checks++; if (bus4.occ !== 3'(expOcc4())) begin fails++; $display("[TB] FAIL drain_occ: got %0d expected %0d", bus4.occ, expOcc4()); end
    end
    checks++; if (bus4.occ !== 3'd2 || bus4.full !== 1'b0) begin fails++; $display("[TB] FAIL drain_final: got occ %0d full %b expected occ 2 full 0", bus4.occ, bus4.full); end
  endtask

  task automatic test_stall();
    for (int k = 1; k <= 4; k++) begin
      drive4(1'b1, 1'b0, 8'h90 + 8'(k), 1'b1);
      checks++; if (bus4.q !== shown4.data || bus4.q_valid !== shown4.valid) begin fails++; $display("[TB] FAIL refill_q: got %b/%h expected %b/%h", bus4.q_valid, bus4.q, shown4.valid, shown4.data); end
    end
    checks++; if (bus4.occ !== 3'd4 || bus4.full !== 1'b1) begin fails++; $display("[TB] FAIL refill_full: got occ %0d full %b expected occ 4 full 1", bus4.occ, bus4.full); end
    for (int k = 0; k < 3; k++) begin
      drive4(1'b0, 1'b0, 8'($urandom), 1'($urandom));
      checks++; if (bus4.q !== 8'h91 || bus4.q_valid !== 1'b1) begin fails++; $display("[TB] FAIL stall_q: got %b/%h expected 1/91", bus4.q_valid, bus4.q); end
      checks++; if (bus4.occ !== 3'd4) begin fails++; $display("[TB] FAIL stall_occ: got %0d expected 4", bus4.occ); end
    end
    drive4(1'b1, 1'b0, 8'hC3, 1'b1);
    checks++; if (bus4.q !== shown4.data || bus4.q !== 8'h92) begin fails++; $display("[TB] FAIL resume_q: got %h expected 92", bus4.q); end
    checks++; if (bus4.occ !== 3'(expOcc4())) begin fails++; $display("[TB] FAIL resume_occ: got %0d expected %0d", bus4.occ, expOcc4()); end
  endtask

  task automatic test_flush();
    drive4(1'b1, 1'b1, 8'h77, 1'b1);
    checks++; if (bus4.occ !== 3'd0 || bus4.full !== 1'b0) begin fails++; $display("[TB] FAIL flush_occ: got occ %0d full %b expected occ 0 full 0", bus4.occ, bus4.full); end
    checks++; if (bus4.q !== RV4 || bus4.q_valid !== 1'b0) begin fails++; $display("[TB] FAIL flush_q: got %b/%h expected 0/%h", bus4.q_valid, bus4.q, RV4); end
    drive4(1'b1, 1'b0, 8'h3C, 1'b1);
    checks++; if (bus4.occ !== 3'(expOcc4())) begin fails++; $display("[TB] FAIL post_flush_occ: got %0d expected %0d", bus4.occ, expOcc4()); end
    checks++; if (bus4.q !== shown4.data || bus4.q_valid !== shown4.valid) begin fails++; $display("[TB] FAIL post_flush_q: got %b/%h expected %b/%h", bus4.q_valid, bus4.q, shown4.valid, shown4.data); end
    bus4.en = 1'b0;
  endtask

  task automatic test_tap_sweep();
    logic [3:0] loadVals [3];
    logic [3:0] expTap [4];
    loadVals = '{4'hA, 4'hB, 4'hC};
    expTap   = '{4'hC, 4'hB, 4'hA, 4'hA};
    bus3.d_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus3.en = 1'b1;
      bus3.d  = loadVals[k];
      cycle();
    end
    bus3.en = 1'b0;
    checks++; if (bus3.occ !== 2'd3 || bus3.full !== 1'b1) begin fails++; $display("[TB] FAIL tap_fill: got occ %0d full %b expected occ 3 full 1", bus3.occ, bus3.full); end
    for (int t = 0; t < 4; t++) begin
      bus3.tap = 2'(t);
      #1;
      checks++; if (bus3.q !== expTap[t] || bus3.q_valid !== 1'b1) begin fails++; $display("[TB] FAIL tap_%0d: got %b/%h expected 1/%h", t, bus3.q_valid, bus3.q, expTap[t]); end
    end
  endtask

  task automatic test_async_reset();
    bus3.clr = 1'b1;
    cycle();
    bus3.clr = 1'b0;
    bus3.tap = 2'd1;
    for (int k = 1; k <= 2; k++) begin
      bus3.en = 1'b1;
      bus3.d  = 4'(k);
      cycle();
    end
    bus3.en = 1'b0;
    checks++; if (bus3.occ !== 2'd2 || bus3.q !== 4'h1 || bus3.q_valid !== 1'b1) begin fails++; $display("[TB] FAIL midfill: got occ %0d q %b/%h expected occ 2 q 1/1", bus3.occ, bus3.q_valid, bus3.q); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus3.occ !== 2'd0 || bus3.q !== RV3 || bus3.q_valid !== 1'b0) begin fails++; $display("[TB] FAIL async_rst3: got occ %0d q %b/%h expected occ 0 q 0/%h", bus3.occ, bus3.q_valid, bus3.q, RV3); end
    checks++; if (bus4.occ !== 3'd0 || bus4.q !== RV4) begin fails++; $display("[TB] FAIL async_rst4: got occ %0d q %h expected occ 0 q %h", bus4.occ, bus4.q, RV4); end
    resetModel4();
    #2;
    rst_n = 1'b1;
    bus3.tap = 2'd0;
    bus3.en  = 1'b1;
    bus3.d   = 4'h9;
    drive4(1'b1, 1'b0, 8'h42, 1'b1);
    bus3.en = 1'b0;
    checks++; if (bus3.occ !== 2'd1 || bus3.q !== 4'h9 || bus3.q_valid !== 1'b1) begin fails++; $display("[TB] FAIL post_rst3: got occ %0d q %b/%h expected occ 1 q 1/9", bus3.occ, bus3.q_valid, bus3.q); end
    checks++; if (bus4.occ !== 3'(expOcc4())) begin fails++; $display("[TB] FAIL post_rst4_occ: got %0d expected %0d", bus4.occ, expOcc4()); end
  endtask

  initial begin
    test_reset();
    test_fill_latency();
    test_occupancy();
    test_stall();
    test_flush();
    test_tap_sweep();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dff_pipe.md
# dff_pipe

Parametrised pipeline register: a chain of DEPTH WIDTH-bit D flip-flop stages with per-stage valid tracking, global advance enable, synchronous flush and a run-time selectable output tap. It is the generalised successor of the single-bit D flip-flop and is used wherever data must be delayed by a programmable number of clock cycles with stall support.

## Interface
- WIDTH, 8, data width in bits (>= 1)
- DEPTH, 4, number of stages (>= 1)
- RESET_VAL, 0, value loaded into every data stage on reset and on flush (WIDTH bits)

- CLK  input  1  clock; all state changes on rising edge
- RST  input  1  reset; asynchronous assertion, active-low (RST = 0 resets)
- EN  input  1  advance enable; 1 = shift pipeline one stage, 0 = hold
- CLR  input  1  synchronous flush
- D  input  WIDTH  input data
- D_VALID  input  1  qualifies D
- TAP  input  TAP_W  selects output stage; TAP_W = max(1, clog2(DEPTH))
- Q  output  WIDTH  data of selected stage
- Q_VALID  output  1  valid of selected stage
- OCC  output  OCC_W  number of valid stages; OCC_W = clog2(DEPTH+1)
- FULL  output  1  all DEPTH stages valid

## Operation
- State: data[0..DEPTH-1] (WIDTH each), vld[0..DEPTH-1], occ counter.
- Reset (RST = 0, asynchronous): data[i] = RESET_VAL, vld[i] = 0, occ = 0; therefore Q = RESET_VAL, Q_VALID = 0, OCC = 0, FULL = 0.
- Priority per rising edge: CLR > EN > hold.
- CLR = 1: all data = RESET_VAL, all vld = 0, occ = 0, regardless of EN, D and D_VALID.
- EN = 1, CLR = 0: data[0] <= D, vld[0] <= D_VALID; data[i] <= data[i-1], vld[i] <= vld[i-1] for i >= 1; contents of stage DEPTH-1 are discarded.
- EN = 0, CLR = 0: all state holds; D and D_VALID are ignored.
- occ update on advance: occ <= occ + D_VALID - vld[DEPTH-1] (both terms may apply in the same cycle, giving net 0). occ must equal popcount(vld) at all times; it never exceeds DEPTH or wraps below 0.
- Q = data[TAP], Q_VALID = vld[TAP]; combinational mux from registers only (no D-to-Q path).
- TAP >= DEPTH (possible when DEPTH is not a power of two): clamp to stage DEPTH-1.
- DEPTH = 1: TAP is ignored, and Q and Q_VALID come from stage 0.
- FULL = (occ == DEPTH), decoded from the registered occ.
- Invalid data still moves through the stages: data bits shift whether or not the valid bit is set. Only vld determines whether a stage is valid.

## Timing
- Latency with EN held at 1: a sample presented at edge n appears on Q at edge n + TAP (that is, TAP+1 edges after D is sampled), with TAP = 0 meaning Q shows it right after the capturing edge.
- With stalls, latency equals TAP+1 enabled edges; cycles with EN = 0 add no stage movement.
- Changing TAP changes Q and Q_VALID in the same cycle (combinational); pipeline state is unaffected.
- OCC and FULL update on the same edge as the stage shift or flush.
- A reset asserted mid-operation clears all state immediately, without waiting for a clock edge. On the first edge after RST deasserts, normal priority applies.

## Structure
- Shared package/header dff_pipe_pkg: clog2 function and derived constants TAP_W, OCC_W.
- Sub-module dff_stage: one WIDTH+1-bit register (data plus valid) with asynchronous active-low reset, synchronous clear and enable, and a RESET_VAL parameter. dff_pipe instantiates DEPTH of these with a generate loop, then adds the occ counter, the FULL decode and the TAP mux.

## Test plan
- Reset then hold: RST = 0 for 2 cycles, then 1 with EN = 0 → Q = RESET_VAL, Q_VALID = 0, OCC = 0, FULL = 0; state remains unchanged over 5 edges.
- Fill and latency (WIDTH = 8, DEPTH = 4, TAP = 3): EN = 1, D_VALID = 1, D = 0x11, 0x22, 0x33, 0x44 → Q = 0x11 with Q_VALID = 1 on the 4th edge; OCC counts 1, 2, 3, 4; FULL = 1 after the 4th edge.
- Steady-state occupancy: pipeline full, keep D_VALID = 1 → OCC stays at 4. Then drive D_VALID = 0 for 2 edges → OCC = 2 and FULL = 0.
- Stall: full pipe, EN = 0 for 3 cycles while D changes → Q and OCC unchanged. EN = 1 → the next sample shifts exactly one stage.
- Flush vs enable: CLR = 1 and EN = 1 with D_VALID = 1 on the same edge → all vld = 0, OCC = 0, Q = RESET_VAL.
- TAP sweep and clamp (DEPTH = 3, TAP_W = 2): after loading 0xA, 0xB, 0xC, TAP = 0, 1, 2, 3 → Q = 0xC, 0xB, 0xA, 0xA. Also assert RST = 0 mid-fill, between clock edges → outputs reset immediately.
